// File: rtl/apb_periph_demux_if.sv
// APB fan-out bundle: one upstream requester port plus NUM_SUBS broadcast peripheral ports.
// The demux connects through 'slave'; the requester/peripheral side connects through 'master'.
interface apb_periph_demux_if #(
    parameter int NUM_SUBS = 4
);
    logic                     s_psel;
    logic                     s_penable;
    logic                     s_pwrite;
    logic [31:0]              s_paddr;
    logic [31:0]              s_pwdata;
    logic [3:0]               s_pstrb;
    logic [2:0]               s_pprot;
    logic [31:0]              s_prdata;
    logic                     s_pready;
    logic                     s_pslverr;

    logic [NUM_SUBS-1:0]      m_psel;
    logic                     m_penable;
    logic [31:0]              m_paddr;
    logic                     m_pwrite;
    logic [31:0]              m_pwdata;
    logic [3:0]               m_pstrb;
    logic [2:0]               m_pprot;
    logic [32*NUM_SUBS-1:0]   m_prdata;
    logic [NUM_SUBS-1:0]      m_pready;
    logic [NUM_SUBS-1:0]      m_pslverr;

    modport slave (
        input  s_psel, s_penable, s_pwrite, s_paddr, s_pwdata, s_pstrb, s_pprot,
        output s_prdata, s_pready, s_pslverr,
        output m_psel, m_penable, m_paddr, m_pwrite, m_pwdata, m_pstrb, m_pprot,
        input  m_prdata, m_pready, m_pslverr
    );

    modport master (
        output s_psel, s_penable, s_pwrite, s_paddr, s_pwdata, s_pstrb, s_pprot,
        input  s_prdata, s_pready, s_pslverr,
        input  m_psel, m_penable, m_paddr, m_pwrite, m_pwdata, m_pstrb, m_pprot,
        output m_prdata, m_pready, m_pslverr
    );
endinterface

// File: rtl/apb_periph_demux.sv
// APB address-decoded fan-out to NUM_SUBS peripherals, with decode-error completion
// and a wait-state timeout so a stuck peripheral can never hang the requester.
module apb_periph_demux #(
    parameter int          NUM_SUBS      = 4,
    parameter logic [31:0] BASE_ADDR     = 32'h0300_0000,
    parameter int          SUB_SPAN_BITS = 12,
    parameter int          TIMEOUT_CYC   = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    apb_periph_demux_if.slave    bus,
    output logic                 decerr_o,
    output logic                 timeout_o,
    output logic [7:0]           err_cnt_o
);

    localparam int          IDX_W   = (NUM_SUBS > 1) ? $clog2(NUM_SUBS) : 1;
    localparam int          TAG_LSB = SUB_SPAN_BITS + IDX_W;
    localparam logic [15:0] TMO     = TIMEOUT_CYC[15:0];
    localparam bit          TMO_EN  = (TIMEOUT_CYC != 0);
    localparam logic [IDX_W:0] NUM_L = NUM_SUBS[IDX_W:0];

    typedef enum logic [1:0] {IDLE, ACCESS, DECERR} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx, idx_q, idx_d;
    logic              hit;
    logic [15:0]       cnt_q, cnt_d;
    logic              sel_ready, sel_err;
    logic [31:0]       sel_rdata;

    assign idx = bus.s_paddr[SUB_SPAN_BITS +: IDX_W];
    assign hit = (bus.s_paddr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]) && ({1'b0, idx} < NUM_L);

    assign sel_ready = bus.m_pready[idx_q];
    assign sel_err   = bus.m_pslverr[idx_q];
    assign sel_rdata = bus.m_prdata[32*idx_q +: 32];

    // Address/data phase signals are broadcast; only psel steers the transfer.
    assign bus.m_paddr  = bus.s_paddr;
    assign bus.m_pwrite = bus.s_pwrite;
    assign bus.m_pwdata = bus.s_pwdata;
    assign bus.m_pstrb  = bus.s_pstrb;
    assign bus.m_pprot  = bus.s_pprot;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        bus.m_psel    = '0;
        bus.m_penable = 1'b0;
        bus.s_pready  = 1'b0;
        bus.s_pslverr = 1'b0;
        bus.s_prdata  = '0;
        decerr_o      = 1'b0;
        timeout_o     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.s_psel && !bus.s_penable) begin
                    for (int i = 0; i < NUM_SUBS; i++) begin
                        bus.m_psel[i] = hit && (idx == IDX_W'(i));
                    end
                    idx_d   = idx;
                    state_d = hit ? ACCESS : DECERR;
                end
            end
            ACCESS: begin
                if (!bus.s_psel) begin
                    // Requester abandoned the transfer: drop out silently.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    for (int i = 0; i < NUM_SUBS; i++) begin
                        bus.m_psel[i] = (idx_q == IDX_W'(i));
                    end
                    bus.m_penable = bus.s_penable;
                    bus.s_pslverr = sel_err;
                    if (sel_ready) begin
                        bus.s_pready = 1'b1;
                        bus.s_prdata = sel_rdata;
                        state_d      = IDLE;
                        cnt_d        = '0;
                    end else if (TMO_EN && (cnt_q == TMO)) begin
                        bus.s_pready  = 1'b1;
                        bus.s_pslverr = 1'b1;
                        timeout_o     = 1'b1;
                        state_d       = IDLE;
                        cnt_d         = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            DECERR: begin
                if (!bus.s_psel) begin
                    state_d = IDLE;
                end else begin
                    bus.s_pready  = 1'b1;
                    bus.s_pslverr = 1'b1;
                    decerr_o      = 1'b1;
                    state_d       = IDLE;
                end
                cnt_d = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_o <= '0;
        end else if ((decerr_o || timeout_o) && (err_cnt_o != 8'hFF)) begin
            err_cnt_o <= err_cnt_o + 8'd1;
        end
    end

endmodule

// File: tb/tb_apb_periph_demux.sv
// Bench for apb_periph_demux: directed APB transfers, expected completions queued and checked by a monitor.
module tb_apb_periph_demux;

    localparam int NS = 4;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       decerr, tmo;
    logic [7:0] err_cnt;

    always #5 clk = ~clk;

    apb_periph_demux_if #(.NUM_SUBS(NS)) bus ();

    apb_periph_demux #(
        .NUM_SUBS     (NS),
        .BASE_ADDR    (32'h0300_0000),
        .SUB_SPAN_BITS(12),
        .TIMEOUT_CYC  (8)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .bus      (bus.slave),
        .decerr_o (decerr),
        .timeout_o(tmo),
        .err_cnt_o(err_cnt)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        slverr;
        int          waits;
        logic        dec;
        logic        tmo;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   mon_waits = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Completion monitor: counts access-phase wait cycles and scores each completion.
    always @(negedge clk) begin
        if (!rst_ni) begin
            mon_waits = 0;
            sb.delete();
        end else if (bus.s_psel && bus.s_penable) begin
            if (bus.s_pready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_completion", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("prdata", bus.s_prdata, mon_e.rdata);
                    chk("pslverr", bus.s_pslverr, mon_e.slverr);
                    chk("wait_states", mon_waits, mon_e.waits);
                    chk("decerr_pulse", decerr, mon_e.dec);
                    chk("timeout_pulse", tmo, mon_e.tmo);
                end
                mon_waits = 0;
            end else begin
                mon_waits++;
            end
        end
    end

    // Starts at posedge+1 with the setup phase; returns at posedge+1 with the bus idle,
    // so consecutive calls are back-to-back. sub<0: no peripheral responds.
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        input int sub, input int waits, input logic [31:0] rdata, input logic perr,
                        input logic [NS-1:0] exp_psel,
                        input logic [31:0] e_rdata, input logic e_err, input int e_waits,
                        input logic e_dec, input logic e_tmo);
        exp_t e;
        int   w;
        bit   done;
        e.rdata = e_rdata; e.slverr = e_err; e.waits = e_waits; e.dec = e_dec; e.tmo = e_tmo;
        sb.push_back(e);
        bus.s_psel    = 1'b1;
        bus.s_penable = 1'b0;
        bus.s_paddr   = addr;
        bus.s_pwrite  = wr;
        bus.s_pwdata  = wdata;
        bus.s_pstrb   = 4'hF;
        bus.s_pprot   = 3'b000;
        @(negedge clk);
        chk("setup_psel", bus.m_psel, exp_psel);
        chk("setup_penable", bus.m_penable, 1'b0);
        @(posedge clk); #1;
        bus.s_penable = 1'b1;
        w = 0;
        done = 1'b0;
        while (!done) begin
            if (sub >= 0 && w == waits) begin
                bus.m_pready[sub]          = 1'b1;
                bus.m_pslverr[sub]         = perr;
                bus.m_prdata[32*sub +: 32] = rdata;
            end
            @(negedge clk);
            if (bus.s_pready) begin
                done = 1'b1;
                chk("access_psel", bus.m_psel, exp_psel);
            end else if (w >= 40) begin
                chk("xfer_bound_expired", 64'd1, 64'd0);
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
                w++;
            end
        end
        @(posedge clk); #1;
        bus.s_psel    = 1'b0;
        bus.s_penable = 1'b0;
        bus.m_pready  = '0;
        bus.m_pslverr = '0;
        bus.m_prdata  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.s_psel = 1'b0; bus.s_penable = 1'b0; bus.s_pwrite = 1'b0;
        bus.s_paddr = '0; bus.s_pwdata = '0; bus.s_pstrb = '0; bus.s_pprot = '0;
        bus.m_prdata = '0; bus.m_pready = '0; bus.m_pslverr = '0;
        rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_psel", bus.m_psel, 4'b0000);
        chk("rst_penable", bus.m_penable, 1'b0);
        chk("rst_pready", bus.s_pready, 1'b0);
        chk("rst_pslverr", bus.s_pslverr, 1'b0);
        chk("rst_prdata", bus.s_prdata, 32'h0);
        chk("rst_pulses", {decerr, tmo}, 2'b00);
        chk("rst_err_cnt", err_cnt, 8'd0);
        rst_ni = 1'b1;
        @(posedge clk); #1;

        // Read sub1, two wait states
        xfer(32'h0300_1004, 1'b0, 32'h0, 1, 2, 32'hCAFE_F00D, 1'b0, 4'b0010,
             32'hCAFE_F00D, 1'b0, 2, 1'b0, 1'b0);
        chk("err_cnt_after_read", err_cnt, 8'd0);

        // Write outside the window
        xfer(32'h0400_0000, 1'b1, 32'h1234_5678, -1, 0, 32'h0, 1'b0, 4'b0000,
             32'h0, 1'b1, 0, 1'b1, 1'b0);
        chk("err_cnt_after_decerr", err_cnt, 8'd1);

        // Back-to-back: write sub0, read sub3, then peripheral error from sub2
        xfer(32'h0300_0000, 1'b1, 32'hA5A5_A5A5, 0, 0, 32'h0, 1'b0, 4'b0001,
             32'h0, 1'b0, 0, 1'b0, 1'b0);
        xfer(32'h0300_3008, 1'b0, 32'h0, 3, 0, 32'h3333_3333, 1'b0, 4'b1000,
             32'h3333_3333, 1'b0, 0, 1'b0, 1'b0);
        xfer(32'h0300_2FFC, 1'b0, 32'h0, 2, 1, 32'h0BAD_0BAD, 1'b1, 4'b0100,
             32'h0BAD_0BAD, 1'b1, 1, 1'b0, 1'b0);
        chk("err_cnt_after_slverr", err_cnt, 8'd1);

        // Sub2 never ready: timeout after 8 waits
        xfer(32'h0300_2000, 1'b0, 32'h0, -1, 0, 32'h0, 1'b0, 4'b0100,
             32'h0, 1'b1, 8, 1'b0, 1'b1);
        @(negedge clk);
        chk("psel_after_timeout", bus.m_psel, 4'b0000);
        chk("err_cnt_after_timeout", err_cnt, 8'd2);
        @(posedge clk); #1;

        // Sub2 ready exactly at the 8th wait: peripheral wins
        xfer(32'h0300_2010, 1'b0, 32'h0, 2, 8, 32'h2222_0008, 1'b0, 4'b0100,
             32'h2222_0008, 1'b0, 8, 1'b0, 1'b0);
        chk("err_cnt_after_race", err_cnt, 8'd2);

        // Reset in the middle of an access to sub1
        bus.s_psel = 1'b1; bus.s_penable = 1'b0; bus.s_pwrite = 1'b0;
        bus.s_paddr = 32'h0300_1000;
        @(posedge clk); #1;
        bus.s_penable = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_ni = 1'b0;
        bus.m_pready[1] = 1'b1;
        bus.m_pslverr[1] = 1'b1;
        bus.m_prdata[63:32] = 32'hDEAD_BEEF;
        #1;
        chk("midrst_psel", bus.m_psel, 4'b0000);
        chk("midrst_penable", bus.m_penable, 1'b0);
        chk("midrst_pready", bus.s_pready, 1'b0);
        chk("midrst_pslverr", bus.s_pslverr, 1'b0);
        chk("midrst_prdata", bus.s_prdata, 32'h0);
        chk("midrst_err_cnt", err_cnt, 8'd0);
        bus.s_psel = 1'b0; bus.s_penable = 1'b0;
        bus.m_pready = '0; bus.m_pslverr = '0; bus.m_prdata = '0;
        @(posedge clk); #1;
        rst_ni = 1'b1;
        @(posedge clk); #1;
        xfer(32'h0300_1000, 1'b0, 32'h0, 1, 1, 32'h1111_2222, 1'b0, 4'b0010,
             32'h1111_2222, 1'b0, 1, 1'b0, 1'b0);

        // 300 decode misses saturate the error counter
        for (int i = 0; i < 300; i++) begin
            xfer(32'h0500_0000 + 32'(i * 4), 1'b0, 32'h0, -1, 0, 32'h0, 1'b0, 4'b0000,
                 32'h0, 1'b1, 0, 1'b1, 1'b0);
            if (i == 253) chk("err_cnt_254", err_cnt, 8'd254);
        end
        chk("err_cnt_saturated", err_cnt, 8'd255);

        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
